// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package inst_fetch_pkg;

  // Fetch sequencer states: WAIT primes the ROM after reset, RUN presents
  // instructions, FLUSH squashes the sequential word fetched under a redirect.
  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  localparam int INST_W         = 32;  // instruction word width
  localparam int CNT_W          = 32;  // accepted-instruction counter width
  localparam int BR_OFF_W       = 16;  // branch immediate (word offset) width
  localparam int JMP_IDX_W      = 26;  // jump index field width
  localparam int JMP_REGION_LSB = 28;  // PC bits at and above this are kept on a jump

endpackage

// File: rtl/inst_fetch_npc_calc.sv
// Redirect target and sequential next-PC computation, all relative to the PC
// of the instruction currently presented to the CPU.
module inst_fetch_npc_calc
  import inst_fetch_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0]      pc_i,
  input  logic [BR_OFF_W-1:0]  branch_off_i,
  input  logic [JMP_IDX_W-1:0] jump_idx_i,
  input  logic                 branch_en_i,
  input  logic                 jump_en_i,
  output logic [PC_W-1:0]      target_o,
  output logic [PC_W-1:0]      pc_plus4_o
);

  logic [PC_W-1:0] br_disp;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] jmp_target;

  assign pc_plus4_o = pc_i + PC_W'(4);

  // Word offset becomes a sign-extended byte displacement.
  assign br_disp    = {{(PC_W-BR_OFF_W-2){branch_off_i[BR_OFF_W-1]}}, branch_off_i, 2'b00};
  assign br_target  = pc_plus4_o + br_disp;

  // Jump stays inside the 256 MB region of the delay-slot address.
  assign jmp_target = {pc_plus4_o[PC_W-1:JMP_REGION_LSB], jump_idx_i, 2'b00};

  // Jump has priority when both are asserted.
  assign target_o   = jump_en_i   ? jmp_target :
                      branch_en_i ? br_target  : pc_plus4_o;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, addresses a 1-cycle-latency ROM,
// presents instruction + PC to the CPU, applies redirects and holds under stall.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              ROM_AW   = 6,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 branch_en,
  input  logic [BR_OFF_W-1:0]  branch_off,
  input  logic                 jump_en,
  input  logic [JMP_IDX_W-1:0] jump_idx,
  output logic [ROM_AW-1:0]    rom_addr,
  input  logic [INST_W-1:0]    rom_data,
  output logic [INST_W-1:0]    Inst_code,
  output logic                 inst_valid,
  output logic [PC_W-1:0]      PC,
  output logic [PC_W-1:0]      PC_plus4,
  output logic [CNT_W-1:0]     inst_count
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_f_q, pc_f_d;      // address being fetched
  logic [PC_W-1:0]   pc_d_q, pc_d_d;      // PC of the word now on rom_data
  logic              hold_valid_q, hold_valid_d;
  logic [INST_W-1:0] hold_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [PC_W-1:0]   pc_f_inc;
  logic [PC_W-1:0]   target;
  logic              accept;
  logic              redirect;
  logic              hold_load;

  inst_fetch_npc_calc #(.PC_W(PC_W)) u_npc_calc (
    .pc_i         (pc_d_q),
    .branch_off_i (branch_off),
    .jump_idx_i   (jump_idx),
    .branch_en_i  (branch_en),
    .jump_en_i    (jump_en),
    .target_o     (target),
    .pc_plus4_o   (PC_plus4)
  );

  assign inst_valid = (state_q == ST_RUN);
  assign accept     = inst_valid & ~stall;
  assign redirect   = accept & (branch_en | jump_en);
  assign pc_f_inc   = pc_f_q + PC_W'(4);
  assign hold_load  = inst_valid & stall & ~hold_valid_q;

  assign rom_addr   = pc_f_q[ROM_AW+1:2];
  assign Inst_code  = hold_valid_q ? hold_q : rom_data;
  assign PC         = pc_d_q;
  assign inst_count = cnt_q;

  // Next-state logic for the fetch sequencer, PCs, hold flag and counter.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    pc_d_d       = pc_d_q;
    hold_valid_d = hold_valid_q;
    cnt_d        = accept ? cnt_q + CNT_W'(1) : cnt_q;

    unique case (state_q)
      ST_WAIT: begin
        pc_f_d  = pc_f_inc;
        pc_d_d  = pc_f_q;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stall) begin
          // PCs freeze; the ROM re-reads pc_f, so the current word must be held.
          if (!hold_valid_q) hold_valid_d = 1'b1;
        end else begin
          pc_f_d       = redirect ? target : pc_f_inc;
          pc_d_d       = pc_f_q;
          hold_valid_d = 1'b0;
          if (redirect) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        pc_f_d       = pc_f_inc;
        pc_d_d       = pc_f_q;
        hold_valid_d = 1'b0;
        state_d      = ST_RUN;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Control and PC state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q      <= ST_WAIT;
      pc_f_q       <= RESET_PC;
      pc_d_q       <= RESET_PC;
      hold_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      pc_d_q       <= pc_d_d;
      hold_valid_q <= hold_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  // Captures the presented word on the first stalled cycle.
  // NOTE: data register left unreset; hold_valid_q gates every use of it.
  always_ff @(posedge clk) begin
    if (hold_load) hold_q <= rom_data;
  end

endmodule
